// File: rtl/gesture_if.sv
// Classifier-result / gesture-event bundle between the classifier back end and the decision filter.
interface gesture_if #(
  parameter int NUM_CLASSES = 4,
  parameter int ACC_BITS    = 24
);
  logic                            result_valid;
  logic [1:0]                      best_class;
  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat;
  logic                            history_clear;
  logic                            gesture_valid;
  logic [1:0]                      gesture_class;
  logic [ACC_BITS-1:0]             gesture_margin;
  logic                            cooldown_active;

  modport master (
    output result_valid, best_class, scores_flat, history_clear,
    input  gesture_valid, gesture_class, gesture_margin, cooldown_active
  );

  modport slave (
    input  result_valid, best_class, scores_flat, history_clear,
    output gesture_valid, gesture_class, gesture_margin, cooldown_active
  );
endinterface

// File: rtl/gesture_decision_filter.sv
// Turns per-window classifier results into debounced gesture events: margin check,
// majority vote over a sliding history, then a cooldown during which results are dropped.
module gesture_decision_filter #(
  parameter int NUM_CLASSES     = 4,
  parameter int ACC_BITS        = 24,
  parameter int HISTORY_LEN     = 5,
  parameter int VOTE_MIN        = 3,
  parameter int MARGIN_MIN      = 256,
  parameter int COOLDOWN_CYCLES = 16
) (
  input logic     clk,
  input logic     rst,
  gesture_if.slave bus
);
  localparam int CNT_W  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam int VOTE_W = $clog2(HISTORY_LEN + 1);
  localparam logic signed [ACC_BITS:0] SAT_MAX = {2'b00, {(ACC_BITS-1){1'b1}}};

  typedef enum logic {S_LISTEN, S_COOLDOWN} state_t;

  typedef struct packed {
    logic                conf;
    logic [1:0]          cls;
    logic [ACC_BITS-1:0] margin;
  } hist_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        s1_valid_q, s1_valid_d;
  logic [1:0]                  s1_class_q, s1_class_d;
  logic [ACC_BITS-1:0]         s1_margin_q, s1_margin_d;
  logic                        s2_new_q, s2_new_d;
  hist_t [HISTORY_LEN-1:0]     hist_q, hist_d;
  logic                        gesture_valid_q, gesture_valid_d;
  logic [1:0]                  gesture_class_q, gesture_class_d;
  logic [ACC_BITS-1:0]         gesture_margin_q, gesture_margin_d;

  logic signed [ACC_BITS-1:0]  score_k, best_score, max_other;
  logic signed [ACC_BITS:0]    diff;
  logic                        class_ok;
  logic [ACC_BITS-1:0]         margin_calc;
  logic [VOTE_W-1:0]           vote_cnt;
  logic                        winner_found, fire;
  logic [1:0]                  win_cls;

  // Stage 1: margin of the argmax over the strongest competitor, clamped to [0, SAT_MAX].
  always_comb begin
    score_k    = '0;
    best_score = '0;
    max_other  = {1'b1, {(ACC_BITS-1){1'b0}}};
    class_ok   = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      score_k = $signed(bus.scores_flat[k*ACC_BITS +: ACC_BITS]);
      if (bus.best_class == 2'(k)) begin
        best_score = score_k;
        class_ok   = 1'b1;
      end else if (score_k > max_other) begin
        max_other = score_k;
      end
    end
    diff = $signed({best_score[ACC_BITS-1], best_score}) - $signed({max_other[ACC_BITS-1], max_other});
    if (!class_ok || diff < 0) margin_calc = '0;
    else if (diff > SAT_MAX)   margin_calc = SAT_MAX[ACC_BITS-1:0];
    else                       margin_calc = diff[ACC_BITS-1:0];
  end

  // Stage 3: vote count per class over the current history; 2*VOTE_MIN > HISTORY_LEN keeps the winner unique.
  always_comb begin
    vote_cnt     = '0;
    winner_found = 1'b0;
    win_cls      = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      vote_cnt = '0;
      for (int i = 0; i < HISTORY_LEN; i++) begin
        if (hist_q[i].conf && hist_q[i].cls == 2'(c)) vote_cnt = vote_cnt + VOTE_W'(1);
      end
      if (vote_cnt >= VOTE_W'(VOTE_MIN)) begin
        winner_found = 1'b1;
        win_cls      = 2'(c);
      end
    end
    fire = s2_new_q && (state_q == S_LISTEN) && winner_found;
  end

  always_comb begin
    s1_valid_d       = bus.result_valid && (state_q == S_LISTEN) && !bus.history_clear && !fire;
    s1_class_d       = bus.best_class;
    s1_margin_d      = margin_calc;
    s2_new_d         = s1_valid_q && !bus.history_clear && !fire;
    hist_d           = hist_q;
    gesture_valid_d  = fire;
    gesture_class_d  = gesture_class_q;
    gesture_margin_d = gesture_margin_q;
    if (bus.history_clear || fire) begin
      hist_d = '0;
    end else if (s1_valid_q) begin
      for (int i = HISTORY_LEN - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0].conf   = (s1_margin_q >= ACC_BITS'(MARGIN_MIN));
      hist_d[0].cls    = s1_class_q;
      hist_d[0].margin = s1_margin_q;
    end
    if (fire) begin
      gesture_class_d  = win_cls;
      gesture_margin_d = hist_q[0].margin;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LISTEN: begin
        if (fire && COOLDOWN_CYCLES > 0) begin
          state_d = S_COOLDOWN;
          cnt_d   = CNT_W'(COOLDOWN_CYCLES);
        end
      end
      S_COOLDOWN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_LISTEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LISTEN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_LISTEN;
      cnt_q            <= '0;
      s1_valid_q       <= 1'b0;
      s1_class_q       <= '0;
      s1_margin_q      <= '0;
      s2_new_q         <= 1'b0;
      hist_q           <= '0;
      gesture_valid_q  <= 1'b0;
      gesture_class_q  <= '0;
      gesture_margin_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      s1_valid_q       <= s1_valid_d;
      s1_class_q       <= s1_class_d;
      s1_margin_q      <= s1_margin_d;
      s2_new_q         <= s2_new_d;
      hist_q           <= hist_d;
      gesture_valid_q  <= gesture_valid_d;
      gesture_class_q  <= gesture_class_d;
      gesture_margin_q <= gesture_margin_d;
    end
  end

  assign bus.gesture_valid   = gesture_valid_q;
  assign bus.gesture_class   = gesture_class_q;
  assign bus.gesture_margin  = gesture_margin_q;
  assign bus.cooldown_active = (state_q == S_COOLDOWN);
endmodule

// File: tb/tb_gesture_decision_filter.sv
// Scoreboard bench: stimulus pushes expected events, per-DUT monitors pop and compare on gesture_valid.
module tb_gesture_decision_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [1:0]  cls;
    logic [23:0] margin;
    int          at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  gesture_if #(.NUM_CLASSES(4), .ACC_BITS(24)) bus_a();
  gesture_if #(.NUM_CLASSES(3), .ACC_BITS(24)) bus_b();

  gesture_decision_filter #(.NUM_CLASSES(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  gesture_decision_filter #(.NUM_CLASSES(3)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.gesture_valid === 1'b1) begin : mon_a
      exp_t e;
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_event: unexpected event class %0d margin %0d at cyc %0d", bus_a.gesture_class, bus_a.gesture_margin, cyc);
      end else begin
        e = q_a.pop_front();
        if (bus_a.gesture_class !== e.cls || bus_a.gesture_margin !== e.margin || cyc != e.at) begin
          n_fail++;
          $display("FAIL a_event: got class %0d margin %0d cyc %0d, expected class %0d margin %0d cyc %0d",
                   bus_a.gesture_class, bus_a.gesture_margin, cyc, e.cls, e.margin, e.at);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.gesture_valid === 1'b1) begin : mon_b
      exp_t e;
      n_tests++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_event: unexpected event class %0d margin %0d at cyc %0d", bus_b.gesture_class, bus_b.gesture_margin, cyc);
      end else begin
        e = q_b.pop_front();
        if (bus_b.gesture_class !== e.cls || bus_b.gesture_margin !== e.margin || cyc != e.at) begin
          n_fail++;
          $display("FAIL b_event: got class %0d margin %0d cyc %0d, expected class %0d margin %0d cyc %0d",
                   bus_b.gesture_class, bus_b.gesture_margin, cyc, e.cls, e.margin, e.at);
        end
      end
    end
  end

  task automatic send_a(input logic [1:0] c, input logic [23:0] s0, s1, s2, s3);
    bus_a.best_class   = c;
    bus_a.scores_flat  = {s3, s2, s1, s0};
    bus_a.result_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.result_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_b(input logic [1:0] c, input logic [23:0] s0, s1, s2);
    bus_b.best_class   = c;
    bus_b.scores_flat  = {s2, s1, s0};
    bus_b.result_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.result_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic expect_a(input logic [1:0] c, input logic [23:0] m);
    exp_t e;
    e.cls = c; e.margin = m; e.at = last_cyc + 2;
    q_a.push_back(e);
  endtask

  task automatic expect_b(input logic [1:0] c, input logic [23:0] m);
    exp_t e;
    e.cls = c; e.margin = m; e.at = last_cyc + 2;
    q_b.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_a.history_clear = 1'b1;
    @(posedge clk); #1;
    bus_a.history_clear = 1'b0;
  endtask

  task automatic wait_cool_end();
    int n = 0;
    while (bus_a.cooldown_active === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_cooldown_ends", bus_a.cooldown_active, 0);
  endtask

  initial begin
    int e;
    bus_a.result_valid = 0; bus_a.best_class = 0; bus_a.scores_flat = '0; bus_a.history_clear = 0;
    bus_b.result_valid = 0; bus_b.best_class = 0; bus_b.scores_flat = '0; bus_b.history_clear = 0;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_gesture_valid", bus_a.gesture_valid, 0);
    check("rst_gesture_class", bus_a.gesture_class, 0);
    check("rst_gesture_margin", bus_a.gesture_margin, 0);
    check("rst_cooldown", bus_a.cooldown_active, 0);
    check("rst_b_cooldown", bus_b.cooldown_active, 0);
    rst = 1'b0;

    // 2: three confident class-2 results -> event margin 1000-200, then 16-cycle cooldown
    repeat (3) send_a(2'd2, 24'd100, 24'd50, 24'd1000, 24'd200);
    expect_a(2'd2, 24'd800);
    e = last_cyc + 2;
    wait_until(e);
    check("t2_cooldown_at_event", bus_a.cooldown_active, 1);
    wait_until(e + 1);
    check("t2_event_seen", q_a.size(), 0);
    wait_until(e + 15);
    check("t2_cooldown_last", bus_a.cooldown_active, 1);
    wait_until(e + 16);
    check("t2_cooldown_over", bus_a.cooldown_active, 0);

    // 3: low margin (100) never votes; outputs stay held
    repeat (5) send_a(2'd2, 24'd0, 24'd0, 24'd300, 24'd200);
    wait_until(last_cyc + 4);
    check("t3_held_class", bus_a.gesture_class, 2);
    check("t3_held_margin", bus_a.gesture_margin, 800);

    // 4: 1,2,1,3,1 -> class 1 wins on the 5th
    send_a(2'd1, 24'd0, 24'd1000, 24'd0, 24'd0);
    send_a(2'd2, 24'd0, 24'd0, 24'd1000, 24'd0);
    send_a(2'd1, 24'd0, 24'd1000, 24'd0, 24'd0);
    send_a(2'd3, 24'd0, 24'd0, 24'd0, 24'd1000);
    send_a(2'd1, 24'd0, 24'd1000, 24'd0, 24'd0);
    expect_a(2'd1, 24'd1000);
    wait_until(last_cyc + 3);
    check("t4_event_seen", q_a.size(), 0);
    wait_cool_end();

    // 5: results during cooldown are ignored
    repeat (3) send_a(2'd0, 24'd1000, 24'd0, 24'd0, 24'd0);
    expect_a(2'd0, 24'd1000);
    wait_until(last_cyc + 2);
    repeat (3) send_a(2'd0, 24'd1000, 24'd0, 24'd0, 24'd0);
    check("t5_in_cooldown", bus_a.cooldown_active, 1);
    check("t5_first_event_seen", q_a.size(), 0);
    wait_cool_end();
    repeat (3) send_a(2'd0, 24'd900, 24'd0, 24'd0, 24'd0);
    expect_a(2'd0, 24'd900);
    wait_until(last_cyc + 3);
    check("t5_second_event_seen", q_a.size(), 0);
    wait_cool_end();

    // 6: history_clear and rst both drop partial history
    pulse_rst();
    check("t6_rst_margin", bus_a.gesture_margin, 0);
    check("t6_rst_class", bus_a.gesture_class, 0);
    repeat (2) send_a(2'd3, 24'd0, 24'd0, 24'd0, 24'd1000);
    pulse_clear();
    send_a(2'd3, 24'd0, 24'd0, 24'd0, 24'd1000);
    wait_until(last_cyc + 5);
    pulse_rst();
    repeat (2) send_a(2'd3, 24'd0, 24'd0, 24'd0, 24'd1000);
    pulse_rst();
    send_a(2'd3, 24'd0, 24'd0, 24'd0, 24'd1000);
    wait_until(last_cyc + 5);
    check("t6_no_cooldown", bus_a.cooldown_active, 0);

    // 7a: full-range difference saturates
    repeat (3) send_a(2'd1, 24'h800000, 24'h7FFFFF, 24'h800000, 24'h800000);
    expect_a(2'd1, 24'h7FFFFF);
    wait_until(last_cyc + 3);
    check("t7_sat_event_seen", q_a.size(), 0);
    wait_cool_end();

    // 7b: out-of-range class on a 3-class filter is unconfident
    repeat (3) send_b(2'd3, 24'hFFEC78, 24'hFFEC78, 24'hFFEC78);
    wait_until(last_cyc + 4);
    check("t7_b_no_cooldown", bus_b.cooldown_active, 0);
    repeat (3) send_b(2'd2, 24'd0, 24'd0, 24'd1000);
    expect_b(2'd2, 24'd1000);
    wait_until(last_cyc + 3);
    check("t7_b_event_seen", q_b.size(), 0);

    wait_until(cyc + 20);
    check("final_a_queue_empty", q_a.size(), 0);
    check("final_b_queue_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
